// File: rtl/onchip_mem_bus_adapter.sv
// onchip_mem_bus_adapter
// Bridges 32-bit valid/ready load/store requests from the RV32 core onto one
// port of the 512 x 64-bit on-chip RAM. Requests are decoded and driven onto the
// RAM in the cycle they are accepted. One pending stage then captures the read
// lane. Responses return in order through a small FIFO, so the core can stall
// the response channel.
//
// Optional build macro ONCHIP_ADAPTER_PERF_EN adds three 32-bit event counters
// (ok loads, ok stores, errors) as perf_* outputs.
module onchip_mem_bus_adapter #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  // core request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  // core response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // RAM port
  output logic [8:0]  mem_address,
  output logic [7:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  output logic        mem_clken,
  input  logic [63:0] mem_readdata
`ifdef ONCHIP_ADAPTER_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_err_cnt
`endif
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Request decode
  logic        in_range;
  logic        aligned;
  logic        req_ok;
  logic        fire;
  logic [2:0]  credits_used;

  // Pending stage: request issued to the RAM last edge, waiting for readdata
  logic        pend_valid_q;
  logic        pend_we_q;
  logic        pend_lane_q;
  logic        pend_err_q;

  // Response FIFO
  logic [31:0]     fifo_data_q [RSP_DEPTH];
  logic            fifo_err_q  [RSP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_nxt;
  logic [PtrW-1:0] rd_ptr_nxt;
  logic [2:0]      fifo_cnt_q;
  logic            push;
  logic            pop;
  logic [31:0]     push_data;

  // Address checks and credit-based flow control
  always_comb begin
    in_range     = (req_addr[31:12] == ADDR_BASE[31:12]);
    aligned      = (req_addr[1:0] == 2'b00);
    req_ok       = in_range & aligned;
    // A pop in the same cycle does not return a credit; keeps req_ready off
    // the rsp_ready path.
    credits_used = {2'b00, pend_valid_q} + fifo_cnt_q;
    req_ready    = reset_n & (credits_used < 3'(RSP_DEPTH));
    fire         = req_valid & req_ready;
  end

  // RAM drive, combinational from the request being accepted
  always_comb begin
    mem_chipselect = fire & req_ok;
    mem_write      = fire & req_ok & req_we;
    mem_address    = req_addr[11:3];
    mem_writedata  = {req_wdata, req_wdata};
    if (req_we) begin
      mem_byteenable = req_addr[2] ? {req_wstrb, 4'h0} : {4'h0, req_wstrb};
    end else begin
      mem_byteenable = 8'hFF;
    end
    mem_clken = reset_n;
  end

  // FIFO control and response outputs
  always_comb begin
    push       = pend_valid_q;
    rsp_valid  = reset_n & (fifo_cnt_q != 3'd0);
    pop        = rsp_valid & rsp_ready;
    wr_ptr_nxt = (wr_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_nxt = (rd_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    // Stores and errors carry no data back.
    if (pend_we_q || pend_err_q) begin
      push_data = 32'h0;
    end else begin
      push_data = pend_lane_q ? mem_readdata[63:32] : mem_readdata[31:0];
    end
    rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;
  end

  // Pending stage and FIFO pointers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_lane_q  <= 1'b0;
      pend_err_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= 3'd0;
    end else begin
      pend_valid_q <= fire;
      if (fire) begin
        pend_we_q   <= req_we;
        pend_lane_q <= req_addr[2];
        pend_err_q  <= ~req_ok;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      fifo_cnt_q <= fifo_cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // FIFO storage; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= pend_err_q;
    end
  end

  // Credit accounting guarantees a free slot for every push
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && !pop && fifo_cnt_q == 3'(RSP_DEPTH)))
        else $error("onchip_mem_bus_adapter: response fifo overflow");
    end
  end

`ifdef ONCHIP_ADAPTER_PERF_EN
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;
  logic [31:0] perf_err_q;

  // Event counters per accepted request class; wrap naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_rd_q  <= 32'h0;
      perf_wr_q  <= 32'h0;
      perf_err_q <= 32'h0;
    end else if (fire) begin
      if (!req_ok) begin
        perf_err_q <= perf_err_q + 32'd1;
      end else if (req_we) begin
        perf_wr_q <= perf_wr_q + 32'd1;
      end else begin
        perf_rd_q <= perf_rd_q + 32'd1;
      end
    end
  end

  assign perf_rd_cnt  = perf_rd_q;
  assign perf_wr_cnt  = perf_wr_q;
  assign perf_err_cnt = perf_err_q;
`endif

endmodule

// File: tb/tb_onchip_mem_bus_adapter.sv
// Self-checking bench for onchip_mem_bus_adapter: byte-level reference memory,
// expected-response queue, and a decoupled response monitor.
module tb_onchip_mem_bus_adapter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [8:0]  mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic        mem_clken;
  logic [63:0] mem_readdata = 64'h0;
`ifdef ONCHIP_ADAPTER_PERF_EN
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_err_cnt;
`endif

  onchip_mem_bus_adapter #(
    .ADDR_BASE(32'h8000_0000),
    .RSP_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_address   (mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata)
`ifdef ONCHIP_ADAPTER_PERF_EN
    ,
    .perf_rd_cnt   (perf_rd_cnt),
    .perf_wr_cnt   (perf_wr_cnt),
    .perf_err_cnt  (perf_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered read, byte-enabled write at the address edge
  logic [63:0] ram [512];
  initial for (int i = 0; i < 512; i++) ram[i] = 64'h0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 8; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      mem_readdata <= ram[mem_address];
    end
  end

  // Reference model: byte-addressable 4 KiB window
  logic [7:0] ref_mem [4096];
  initial for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_rd = 0, n_wr = 0, n_bad = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t model(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                 input logic [3:0] ws);
    rsp_t r;
    int   base;
    r.data = 32'h0;
    r.err  = 1'b0;
    base   = int'(a[11:0]);
    if (a < 32'h8000_0000 || a > 32'h8000_0FFF || (a % 4) != 0) begin
      r.err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < 4; i++) if (ws[i]) ref_mem[base + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < 4; i++) r.data[8*i +: 8] = ref_mem[base + i];
    end
    return r;
  endfunction

  // Drive one request, wait (bounded) for acceptance, check the RAM drive
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] ws);
    int          waited;
    logic        ok;
    logic [7:0]  be_exp;
    rsp_t        r;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    req_wstrb = ws;
    #1;
    while (!req_ready && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 64'(req_ready), 64'(1'b1));
      req_valid = 1'b0;
      return;
    end
    ok     = (a[31:12] == 20'h80000) && (a[1:0] == 2'b00);
    be_exp = 8'h00;
    if (!we) be_exp = 8'hFF;
    else for (int i = 0; i < 4; i++) if (ws[i]) be_exp[(a[2] ? 4 : 0) + i] = 1'b1;
    chk("mem_chipselect", 64'(mem_chipselect), 64'(ok));
    chk("mem_write", 64'(mem_write), 64'(ok & we));
    if (ok) begin
      chk("mem_address", 64'(mem_address), 64'((a - 32'h8000_0000) / 8));
      chk("mem_byteenable", 64'(mem_byteenable), 64'(be_exp));
      if (we) chk("mem_writedata", mem_writedata, {wd, wd});
    end
    r = model(a, we, wd, ws);
    exp_q.push_back(r);
    if (!ok) n_bad++;
    else if (we) n_wr++;
    else n_rd++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Response monitor: sample just after the negedge, compare on each pop
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_rsp: got rdata=%0h err=%0b expected none", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  // rsp_ready backpressure during the random phase
  always @(negedge clk) if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    // Reset state, with a valid in-window request presented
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_mem_cs", 64'(mem_chipselect), 64'd0);
    chk("reset_mem_write", 64'(mem_write), 64'd0);
    chk("reset_mem_clken", 64'(mem_clken), 64'd0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_clken", 64'(mem_clken), 64'd1);
    chk("post_reset_req_ready", 64'(req_ready), 64'd1);

    // Store then load of the same word on consecutive cycles
    issue(32'h8000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF);
    issue(32'h8000_0004, 1'b0, 32'h0, 4'h0);
    issue(32'h8000_0000, 1'b1, 32'h1234_5678, 4'b0110);
    issue(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    issue(32'h8000_0008, 1'b1, 32'hCAFE_F00D, 4'h0);
    issue(32'h8000_0008, 1'b0, 32'h0, 4'h0);
    drain();

    // Out-of-window and misaligned: no RAM cycle, error responses in order
    issue(32'h8000_1000, 1'b0, 32'h0, 4'h0);
    issue(32'h8000_0002, 1'b0, 32'h0, 4'h0);
    issue(32'h7FFF_FFFC, 1'b1, 32'h5555_5555, 4'hF);
    issue(32'h8000_0FFC, 1'b0, 32'h0, 4'h0);
    drain();

    // Latency: idle pipeline, response visible two edges after fire
    issue(32'h8000_0004, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    #2;
    chk("latency_edge1_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #2;
    chk("latency_edge2_rsp_valid", 64'(rsp_valid), 64'd1);
    drain();

    // Backpressure: two loads fill the credits, the third stalls
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(32'h8000_0004, 1'b0, 32'h0, 4'h0);
    issue(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0008;
    req_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    issue(32'h8000_0008, 1'b0, 32'h0, 4'h0);
    drain();

    // Randomized traffic with random response backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 19);
      if (sel < 12)      a = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
      else if (sel < 16) a = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      else if (sel < 18) a = (sel == 16) ? 32'h8000_1000 + ($urandom_range(0, 255) << 2)
                                         : 32'h7FFF_F000 + ($urandom_range(0, 1023) << 2);
      else               a = 32'h8000_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(1, 3);
      issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    drain();

    // Reset with two responses queued: dropped, RAM contents kept
    rsp_ready = 1'b0;
    issue(32'h8000_0100, 1'b1, 32'h1122_3344, 4'hF);
    issue(32'h8000_010C, 1'b1, 32'hA5A5_5A5A, 4'b0101);
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    n_rd  = 0;
    n_wr  = 0;
    n_bad = 0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("midreset_edge_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_edge_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk("post_reset_no_stale", 64'(rsp_valid), 64'd0);
    end
    issue(32'h8000_0100, 1'b0, 32'h0, 4'h0);
    issue(32'h8000_010C, 1'b0, 32'h0, 4'h0);
    drain();

`ifdef ONCHIP_ADAPTER_PERF_EN
    // Fixed mix after reset: 5 ok loads, 3 ok stores, 2 errors
    for (int i = 0; i < 5; i++) issue(32'h8000_0200 + 32'(i * 4), 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) issue(32'h8000_0300 + 32'(i * 4), 1'b1, 32'h0BAD_CAFE, 4'hF);
    issue(32'h9000_0000, 1'b0, 32'h0, 4'h0);
    issue(32'h8000_0201, 1'b1, 32'h0, 4'hF);
    drain();
    chk("perf_rd_cnt", 64'(perf_rd_cnt), 64'(n_rd));
    chk("perf_wr_cnt", 64'(perf_wr_cnt), 64'(n_wr));
    chk("perf_err_cnt", 64'(perf_err_cnt), 64'(n_bad));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
